// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, coordinate width and FSM encoding for the 1366x768 LVDS raster generator.
package lcd_timing_pkg;

  localparam int COORD_W   = 11;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  localparam int H_ACTIVE = 1366;
  localparam int H_FP     = 14;
  localparam int H_SYNC   = 56;
  localparam int H_BP     = 104;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 4;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit SYNC_POL = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Every coordinate, including the last one of a line or frame, must be representable.
  function automatic bit fits_coord(input int total);
    return (total >= 1) && (total <= COORD_MAX);
  endfunction

endpackage

// File: rtl/lcd_timing_if.sv
// Run request plus registered raster outputs of the timing generator, grouped for the pixel pipeline.
interface lcd_timing_if;
  import lcd_timing_pkg::*;

  logic               en;
  logic               busy;
  logic               hsync;
  logic               vsync;
  logic               data_en;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [COORD_W-1:0] nxt_x;
  logic [COORD_W-1:0] nxt_y;
  logic               nxt_de;
  logic               line_start;
  logic               frame_start;

  modport master (
    input  en,
    output busy, hsync, vsync, data_en,
    output pos_x, pos_y, nxt_x, nxt_y, nxt_de,
    output line_start, frame_start
  );

  modport slave (
    output en,
    input  busy, hsync, vsync, data_en,
    input  pos_x, pos_y, nxt_x, nxt_y, nxt_de,
    input  line_start, frame_start
  );

endinterface

// File: rtl/lcd_sync_decode.sv
// Combinational raster decode: one (x,y) coordinate pair to data-enable and sync levels.
module lcd_sync_decode
  import lcd_timing_pkg::*;
#(
  parameter int CFG_H_ACTIVE = H_ACTIVE,
  parameter int CFG_H_FP     = H_FP,
  parameter int CFG_H_SYNC   = H_SYNC,
  parameter int CFG_V_ACTIVE = V_ACTIVE,
  parameter int CFG_V_FP     = V_FP,
  parameter int CFG_V_SYNC   = V_SYNC,
  parameter bit CFG_SYNC_POL = SYNC_POL
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               de,
  output logic               hs,
  output logic               vs
);

  localparam logic [COORD_W-1:0] X_ACT_END = COORD_W'(CFG_H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START  = COORD_W'(CFG_H_ACTIVE + CFG_H_FP);
  localparam logic [COORD_W-1:0] HS_END    = COORD_W'(CFG_H_ACTIVE + CFG_H_FP + CFG_H_SYNC);
  localparam logic [COORD_W-1:0] Y_ACT_END = COORD_W'(CFG_V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_START  = COORD_W'(CFG_V_ACTIVE + CFG_V_FP);
  localparam logic [COORD_W-1:0] VS_END    = COORD_W'(CFG_V_ACTIVE + CFG_V_FP + CFG_V_SYNC);

  // The vertical window depends on y only, so vsync edges line up with the start of a line.
  always_comb begin
    de = (x < X_ACT_END) && (y < Y_ACT_END);
    hs = ((x >= HS_START) && (x < HS_END)) ? CFG_SYNC_POL : ~CFG_SYNC_POL;
    vs = ((y >= VS_START) && (y < VS_END)) ? CFG_SYNC_POL : ~CFG_SYNC_POL;
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: FSM and look-ahead counters, with pos-side outputs one cycle behind nxt_*.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int CFG_H_ACTIVE = H_ACTIVE,
  parameter int CFG_H_FP     = H_FP,
  parameter int CFG_H_SYNC   = H_SYNC,
  parameter int CFG_H_BP     = H_BP,
  parameter int CFG_V_ACTIVE = V_ACTIVE,
  parameter int CFG_V_FP     = V_FP,
  parameter int CFG_V_SYNC   = V_SYNC,
  parameter int CFG_V_BP     = V_BP,
  parameter bit CFG_SYNC_POL = SYNC_POL
) (
  input  logic          clk,
  input  logic          rst_n,
  lcd_timing_if.master  tim
);

  localparam int H_TOT = CFG_H_ACTIVE + CFG_H_FP + CFG_H_SYNC + CFG_H_BP;
  localparam int V_TOT = CFG_V_ACTIVE + CFG_V_FP + CFG_V_SYNC + CFG_V_BP;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOT - 1);

  if (!fits_coord(H_TOT) || !fits_coord(V_TOT)) begin : g_param_check
    $error("lcd_timing_gen: timing totals must lie in 1..%0d", COORD_MAX);
  end

  state_t             state, state_nx;
  logic [COORD_W-1:0] la_x, la_y, la_x_nx, la_y_nx;
  logic               la_active, la_at_end;
  logic               la_de_q;
  logic               cur_de, cur_hs, cur_vs;
  logic               nx_de, nx_hs, nx_vs;
  logic               unused_nx_sync;

  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic               busy_q, data_en_q, hsync_q, vsync_q;
  logic               line_start_q, frame_start_q;

  // The FSM and counters track the coordinate presented one cycle later; en is acted on there.
  assign la_active = (state != IDLE);
  assign la_at_end = (la_x == H_LAST) && (la_y == V_LAST);

  always_comb begin
    state_nx = state;
    la_x_nx  = la_x;
    la_y_nx  = la_y;
    case (state)
      IDLE: begin
        la_x_nx = '0;
        la_y_nx = '0;
        if (tim.en) state_nx = RUN;
      end
      RUN, DRAIN: begin
        if (la_at_end) begin
          la_x_nx  = '0;
          la_y_nx  = '0;
          state_nx = tim.en ? RUN : IDLE;
        end else begin
          state_nx = tim.en ? RUN : DRAIN;
          if (la_x == H_LAST) begin
            la_x_nx = '0;
            la_y_nx = la_y + COORD_W'(1);
          end else begin
            la_x_nx = la_x + COORD_W'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        la_x_nx  = '0;
        la_y_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      la_x    <= '0;
      la_y    <= '0;
      la_de_q <= 1'b0;
    end else begin
      state   <= state_nx;
      la_x    <= la_x_nx;
      la_y    <= la_y_nx;
      la_de_q <= (state_nx != IDLE) && nx_de;
    end
  end

  lcd_sync_decode #(
    .CFG_H_ACTIVE(CFG_H_ACTIVE), .CFG_H_FP(CFG_H_FP), .CFG_H_SYNC(CFG_H_SYNC),
    .CFG_V_ACTIVE(CFG_V_ACTIVE), .CFG_V_FP(CFG_V_FP), .CFG_V_SYNC(CFG_V_SYNC),
    .CFG_SYNC_POL(CFG_SYNC_POL)
  ) u_decode_next (
    .x (la_x_nx),
    .y (la_y_nx),
    .de(nx_de),
    .hs(nx_hs),
    .vs(nx_vs)
  );

  lcd_sync_decode #(
    .CFG_H_ACTIVE(CFG_H_ACTIVE), .CFG_H_FP(CFG_H_FP), .CFG_H_SYNC(CFG_H_SYNC),
    .CFG_V_ACTIVE(CFG_V_ACTIVE), .CFG_V_FP(CFG_V_FP), .CFG_V_SYNC(CFG_V_SYNC),
    .CFG_SYNC_POL(CFG_SYNC_POL)
  ) u_decode_cur (
    .x (la_x),
    .y (la_y),
    .de(cur_de),
    .hs(cur_hs),
    .vs(cur_vs)
  );

  assign unused_nx_sync = ^{nx_hs, nx_vs};

  // Pos-side outputs take the look-ahead coordinate and its decode, forced inactive outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      busy_q        <= 1'b0;
      data_en_q     <= 1'b0;
      hsync_q       <= ~CFG_SYNC_POL;
      vsync_q       <= ~CFG_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pos_x_q       <= la_x;
      pos_y_q       <= la_y;
      busy_q        <= la_active;
      data_en_q     <= la_active && cur_de;
      hsync_q       <= la_active ? cur_hs : ~CFG_SYNC_POL;
      vsync_q       <= la_active ? cur_vs : ~CFG_SYNC_POL;
      line_start_q  <= la_active && (la_x == '0);
      frame_start_q <= la_active && (la_x == '0) && (la_y == '0);
    end
  end

  assign tim.busy        = busy_q;
  assign tim.hsync       = hsync_q;
  assign tim.vsync       = vsync_q;
  assign tim.data_en     = data_en_q;
  assign tim.pos_x       = pos_x_q;
  assign tim.pos_y       = pos_y_q;
  assign tim.nxt_x       = la_x;
  assign tim.nxt_y       = la_y;
  assign tim.nxt_de      = la_de_q;
  assign tim.line_start  = line_start_q;
  assign tim.frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen on a small raster, compared against a frame-index model.
module tb_lcd_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit POL = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_on = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lcd_timing_if tim();

  lcd_timing_gen #(
    .CFG_H_ACTIVE(HA), .CFG_H_FP(HF), .CFG_H_SYNC(HS), .CFG_H_BP(HB),
    .CFG_V_ACTIVE(VA), .CFG_V_FP(VF), .CFG_V_SYNC(VS), .CFG_V_BP(VB),
    .CFG_SYNC_POL(POL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tim  (tim)
  );

  always #5 clk = ~clk;

  // Model: a frame is a run of FRAME clocks indexed by k; en only matters when idle or at the last index.
  bit lk_act, pr_act;
  int lk_k, pr_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_act <= 1'b0; lk_k <= 0;
      pr_act <= 1'b0; pr_k <= 0;
    end else begin
      pr_act <= lk_act;
      pr_k   <= lk_k;
      if (!lk_act || lk_k == FRAME - 1) begin
        lk_act <= tim.en;
        lk_k   <= 0;
      end else begin
        lk_k <= lk_k + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic int expDe(input bit act, input int k);
    return (act && (k % HT) < HA && (k / HT) < VA) ? 1 : 0;
  endfunction

  function automatic int expHs(input bit act, input int k);
    int x = k % HT;
    return (act && x >= HA + HF && x < HA + HF + HS) ? int'(POL) : int'(!POL);
  endfunction

  function automatic int expVs(input bit act, input int k);
    int y = k / HT;
    return (act && y >= VA + VF && y < VA + VF + VS) ? int'(POL) : int'(!POL);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("busy",        int'(tim.busy),        int'(pr_act));
      checkOutput("pos_x",       int'(tim.pos_x),       pr_act ? pr_k % HT : 0);
      checkOutput("pos_y",       int'(tim.pos_y),       pr_act ? pr_k / HT : 0);
      checkOutput("data_en",     int'(tim.data_en),     expDe(pr_act, pr_k));
      checkOutput("hsync",       int'(tim.hsync),       expHs(pr_act, pr_k));
      checkOutput("vsync",       int'(tim.vsync),       expVs(pr_act, pr_k));
      checkOutput("line_start",  int'(tim.line_start),  (pr_act && pr_k % HT == 0) ? 1 : 0);
      checkOutput("frame_start", int'(tim.frame_start), (pr_act && pr_k == 0) ? 1 : 0);
      checkOutput("nxt_x",       int'(tim.nxt_x),       lk_act ? lk_k % HT : 0);
      checkOutput("nxt_y",       int'(tim.nxt_y),       lk_act ? lk_k / HT : 0);
      checkOutput("nxt_de",      int'(tim.nxt_de),      expDe(lk_act, lk_k));
    end
  end

  task automatic waitPos(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(tim.pos_x) == x && int'(tim.pos_y) == y && tim.busy) && n < 4 * FRAME);
    checkOutput("wait_pos_x", int'(tim.pos_x), x);
    checkOutput("wait_pos_y", int'(tim.pos_y), y);
  endtask

  task automatic waitFrameStart(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tim.frame_start && n < 4 * FRAME);
    checkOutput("wait_frame_start", int'(tim.frame_start), 1);
  endtask

  task automatic applyStimulus();
    int n, de_cnt, hs_cnt, vs_cnt, ls_cnt, seg;

    // Reset values, held with en low.
    checkOutput("rst_pos_x", int'(tim.pos_x), 0);
    checkOutput("rst_hsync", int'(tim.hsync), 1);
    checkOutput("rst_vsync", int'(tim.vsync), 1);
    checkOutput("rst_busy", int'(tim.busy), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_nxt_de", int'(tim.nxt_de), 0);
    checkOutput("idle_busy", int'(tim.busy), 0);

    // Start: look-ahead DE one cycle before (0,0) is presented.
    tim.en = 1'b1;
    @(negedge clk);
    checkOutput("start_nxt_de", int'(tim.nxt_de), 1);
    checkOutput("start_data_en", int'(tim.data_en), 0);
    @(negedge clk);
    checkOutput("first_frame_start", int'(tim.frame_start), 1);
    checkOutput("first_data_en", int'(tim.data_en), 1);
    checkOutput("first_pos_x", int'(tim.pos_x), 0);

    // One full frame: 4x3 active, hsync low at x=5,6, vsync low on line 4.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      de_cnt += int'(tim.data_en);
      hs_cnt += int'(!tim.hsync);
      vs_cnt += int'(!tim.vsync);
      ls_cnt += int'(tim.line_start);
      @(negedge clk);
    end
    checkOutput("frame_de_cycles", de_cnt, 12);
    checkOutput("frame_hsync_low", hs_cnt, 12);
    checkOutput("frame_vsync_low", vs_cnt, 8);
    checkOutput("frame_line_starts", ls_cnt, 6);
    checkOutput("back_to_back_start", int'(tim.frame_start), 1);

    // Drop en mid-frame, raise it again during drain: frame timing unchanged.
    waitPos(2, 1);
    tim.en = 1'b0;
    waitPos(1, 4);
    tim.en = 1'b1;
    waitFrameStart(n);
    checkOutput("drain_resume_gap", n, 15);
    waitFrameStart(n);
    checkOutput("frame_period", n, FRAME);

    // Stop: the frame runs to its last pixel, then the generator idles.
    tim.en = 1'b0;
    n = 0;
    while (tim.busy && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stop_cycles", n, FRAME);
    checkOutput("stop_data_en", int'(tim.data_en), 0);
    checkOutput("stop_hsync", int'(tim.hsync), 1);

    // Asynchronous reset between clock edges.
    tim.en = 1'b1;
    waitPos(3, 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_busy", int'(tim.busy), 0);
    checkOutput("async_pos_x", int'(tim.pos_x), 0);
    checkOutput("async_pos_y", int'(tim.pos_y), 0);
    checkOutput("async_hsync", int'(tim.hsync), 1);
    checkOutput("async_nxt_de", int'(tim.nxt_de), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("restart_frame_start", int'(tim.frame_start), 1);
    checkOutput("restart_pos_y", int'(tim.pos_y), 0);

    // Random run requests with occasional mid-cycle reset pulses.
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (seg == 0) begin
        tim.en = ($urandom_range(0, 99) < 65);
        seg = $urandom_range(1, 3 * FRAME);
      end
      seg--;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    tim.en = 1'b0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    applyStimulus();
    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
